// File: rtl/uart_rx_monitor.sv
// UART 8N1 receive monitor: 16x-oversampled receiver feeding a first-word-fall-through FIFO.
// Reports bad stop bits as a one-cycle pulse and dropped bytes as a sticky overflow flag.
module uart_rx_monitor #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            sync1, rxd_s, rxd_prev;
  logic [DW-1:0]   div_cnt, div_n;
  logic [3:0]      tick_cnt, tcnt_n;
  logic [2:0]      bit_idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            tick;
  logic            push, ferr_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]   count;
  logic            full, empty, pop, push_ok, drop;

  assign dbg_state = state;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      rxd_s    <= sync1;
      rxd_prev <= rxd_s;
    end
  end

  assign tick = (state != IDLE) && (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      tick_cnt  <= tcnt_n;
      bit_idx   <= idx_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
    end
  end

  // tick_cnt counts oversample ticks within the current bit (or run of idle ticks in BREAK).
  always_comb begin
    state_n = state;
    div_n   = (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
    tcnt_n  = tick_cnt;
    idx_n   = bit_idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        idx_n  = '0;
        if (rxd_prev && !rxd_s) state_n = START;
      end
      START: begin
        if (tick) begin
          if (tick_cnt == 4'd7) begin
            tcnt_n  = '0;
            idx_n   = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            tcnt_n = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == 4'd15) begin
            tcnt_n           = '0;
            shreg_n[bit_idx] = rxd_s;
            if (bit_idx == 3'd7) state_n = STOP;
            else                 idx_n   = bit_idx + 3'd1;
          end else begin
            tcnt_n = tick_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == 4'd15) begin
            tcnt_n = '0;
            if (rxd_s) begin
              push    = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BREAK;
            end
          end else begin
            tcnt_n = tick_cnt + 4'd1;
          end
        end
      end
      BREAK: begin
        if (!rxd_s) begin
          tcnt_n = '0;
        end else if (tick) begin
          if (tick_cnt == 4'd15) begin
            tcnt_n  = '0;
            state_n = IDLE;
          end else begin
            tcnt_n = tick_cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output handshake: a byte transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // out_data is a register holding the head entry, so it keeps its value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr_inc;
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      if (empty && push_ok) begin
        out_data <= shreg;
      end else if (pop) begin
        if (count > CW'(1)) out_data <= mem[rd_ptr_inc];
        else if (push_ok)   out_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at CLK_DIV=4 (64 clk per bit), FIFO_DEPTH=8.
module tb_uart_rx_monitor;

  localparam int BIT_CLKS = 64;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overflow;
  logic [3:0] fifo_count;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cycles = 0;
  int ferr_cnt = 0;
  int extra_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_monitor #(.CLK_DIV(4), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: each accepted byte is compared with the front of exp_q
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn) begin
        if (out_valid) valid_cycles++;
        if (frame_err) ferr_cnt++;
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) check("rx_data", 32'(out_data), 32'(exp_q.pop_front()));
          else extra_cnt++;
        end
      end
    end
  end

  // driver: whole 8N1 frame; rst_bit >= 0 pulses rstn for 1 clk mid-way through that data bit
  task automatic send_byte(input logic [7:0] b, input logic stop, input int rst_bit);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == rst_bit) begin
        repeat (BIT_CLKS / 2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (BIT_CLKS / 2 - 1) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    rxd = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    idle(4);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rxd = 1'b1;
    rstn = 1'b0;
    out_ready = 1'b0;
    idle(5);
    rstn = 1'b1;
    idle(1);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);

    // two back-to-back bytes with consumer always ready
    out_ready = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_byte(8'h55, 1'b1, -1);
    idle(16);
    send_byte(8'hA3, 1'b1, -1);
    idle(16);
    wait_drain("two_bytes_drain");
    check("two_bytes_valid_cycles", 32'(valid_cycles), 32'd2);
    check("two_bytes_ferr", 32'(ferr_cnt), 32'd0);
    check("two_bytes_overflow", 32'(overflow), 32'd0);

    // short low glitch is rejected at the mid-start sample
    rxd = 1'b0;
    idle(20);
    check("glitch_in_start", 32'(dbg_state), 32'(S_START));
    rxd = 1'b1;
    idle(60);
    check("glitch_state", 32'(dbg_state), 32'(S_IDLE));
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_valid_cycles", 32'(valid_cycles), 32'd2);

    // bad stop bit followed by a held-low line, then a good byte
    send_byte(8'h3C, 1'b0, -1);
    rxd = 1'b0;
    idle(200);
    check("break_state", 32'(dbg_state), 32'(S_BREAK));
    check("break_ferr", 32'(ferr_cnt), 32'd1);
    rxd = 1'b1;
    idle(80);
    check("break_exit", 32'(dbg_state), 32'(S_IDLE));
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, -1);
    idle(16);
    wait_drain("after_break_drain");
    check("after_break_ferr", 32'(ferr_cnt), 32'd1);
    check("after_break_count", 32'(fifo_count), 32'd0);

    // fill past capacity with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, -1);
      idle(8);
    end
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_head", 32'(out_data), 32'h01);

    // 10th byte lands on a full FIFO in the same cycle as a single pop
    exp_q.push_back(8'h0A);
    fork
      send_byte(8'h0A, 1'b1, -1);
      begin
        n = 0;
        while (dbg_state != S_STOP && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check("stop_reached", 32'(dbg_state), 32'(S_STOP));
        repeat (63) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        check("push_pop_count", 32'(fifo_count), 32'd8);
        check("push_pop_head", 32'(out_data), 32'h02);
      end
    join
    check("push_pop_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    wait_drain("full_drain");
    check("drained_count", 32'(fifo_count), 32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_hold", 32'(out_data), 32'h0A);

    // reset pulse during data bit 4 aborts the frame and clears overflow
    send_byte(8'hFF, 1'b1, 4);
    idle(16);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, -1);
    idle(16);
    wait_drain("after_rst_drain");

    check("final_ferr", 32'(ferr_cnt), 32'd1);
    check("final_extra", 32'(extra_cnt), 32'd0);
    check("final_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per oversample tick; 16 ticks per bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port rxd, input, 1, asynchronous serial line from chip_top txd; idle high, 8N1, LSB first.
REQ-006 SHALL have port out_data, output, 8, head-of-FIFO byte.
REQ-007 SHALL have port out_valid, output, 1, high when the FIFO is non-empty.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts out_data when out_valid and out_ready are both high.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overflow, output, 1, sticky; set when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current number of FIFO entries.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer, reset to 1; all further rxd references mean the synchronized value.
REQ-013 SHALL generate a one-cycle tick every CLK_DIV clocks; the tick counter is free-running only outside IDLE and is cleared on entering START.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE: a high-to-low transition on rxd moves to START.
REQ-016 START: on the 8th tick, if rxd is 0, move to DATA with bit index 0; if rxd is 1, treat as a glitch and return to IDLE with no output.
REQ-017 DATA: sample rxd every 16 ticks after the mid-start sample into shift register bit[index]; after index 7, move to STOP.
REQ-018 STOP: 16 ticks after the last data sample, sample rxd.
REQ-019 STOP with rxd 1: push the byte and move to IDLE.
REQ-020 STOP with rxd 0: pulse frame_err the next cycle, discard the byte and move to BREAK.
REQ-021 BREAK: remain until rxd is 1 for 16 consecutive ticks, then move to IDLE.
REQ-022 The FIFO SHALL be first-word-fall-through: a pushed byte appears on out_data with out_valid high on the cycle after the stop-bit sample.
REQ-023 A pop SHALL occur when out_valid and out_ready are both high; out_data advances on the next cycle.
REQ-024 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-025 On a simultaneous push and pop, fifo_count SHALL be unchanged.
REQ-026 Otherwise a push to a full FIFO SHALL drop the byte, set overflow, and leave the FIFO contents unchanged.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 fifo_count SHALL range 0..FIFO_DEPTH; out_data SHALL hold its last value while out_valid is 0.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 On any cycle with rstn low, the block SHALL go to IDLE with the tick counter, bit index and shift register cleared.
REQ-031 Reset SHALL empty the FIFO (pointers 0, fifo_count 0) and drive out_valid 0, out_data 0x00, frame_err 0 and overflow 0; the synchronizer resets to 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no push and no frame_err.
REQ-033 After rstn rises, a frame whose start edge falls on or after the first cycle out of reset SHALL be received normally.

Verification (CLK_DIV=4, 64 clk per bit)
REQ-034 Send 0x55 then 0xA3 with out_ready=1 -> out_valid pulses twice, out_data 0x55 then 0xA3, frame_err 0, overflow 0.
REQ-035 Drive rxd low for 20 clk, then high -> no out_valid, state returns to IDLE, fifo_count 0.
REQ-036 Send 0x3C with stop bit 0, hold low for 200 clk, then high, then send 0x7E -> one frame_err pulse, only 0x7E is delivered.
REQ-037 With out_ready=0, send 9 bytes 0x01..0x09 -> fifo_count 8, overflow 1; draining yields 0x01..0x08.
REQ-038 With the FIFO full, assert out_ready in the cycle of the stop sample of a 10th byte 0x0A -> byte accepted, fifo_count stays 8, 0x0A is delivered last.
REQ-039 Assert rstn low for 1 clk during data bit 4 of 0xFF -> no output; the following 0x12 is delivered intact.
